// File: rtl/logic_gate_ctrl_if.sv
// Key inputs and LED/mode outputs of the logic-gate demo controller.
interface logic_gate_ctrl_if;
  logic       key_a_n;
  logic       key_b_n;
  logic       key_mode_n;
  logic       led_out_n;
  logic [3:0] led_mode_n;
  logic [1:0] mode;
  logic       mode_evt;

  modport master (
    output key_a_n, key_b_n, key_mode_n,
    input  led_out_n, led_mode_n, mode, mode_evt
  );

  modport slave (
    input  key_a_n, key_b_n, key_mode_n,
    output led_out_n, led_mode_n, mode, mode_evt
  );
endinterface

// File: rtl/logic_gate_ctrl.sv
// Two-input logic-gate demo: synchronised, debounced keys drive a selectable
// NAND/NOR/XOR/XNOR gate; a mode key steps the function. All LEDs active-low.
module logic_gate_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              rst,
  logic_gate_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_NAND = 2'd0,
    MODE_NOR  = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_XNOR = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  function automatic logic gate_eval(input mode_e m, input logic a, input logic b);
    logic r_s;
    case (m)
      MODE_NAND: r_s = ~(a & b);
      MODE_NOR:  r_s = ~(a | b);
      MODE_XOR:  r_s = a ^ b;
      MODE_XNOR: r_s = ~(a ^ b);
      default:   r_s = 1'b0;
    endcase
    return r_s;
  endfunction

  function automatic logic [3:0] mode_led_n(input mode_e m);
    logic [3:0] r_s;
    case (m)
      MODE_NAND: r_s = 4'b1110;
      MODE_NOR:  r_s = 4'b1101;
      MODE_XOR:  r_s = 4'b1011;
      MODE_XNOR: r_s = 4'b0111;
      default:   r_s = 4'b1111;
    endcase
    return r_s;
  endfunction

  // Key bit order: [0] = operand A, [1] = operand B, [2] = mode key.
  logic [2:0]       raw_s;
  logic [2:0]       sync1_r;
  logic [2:0]       sync2_r;
  logic [2:0]       stable_r;
  logic [CNT_W-1:0] cnt_r [3];

  mode_e      mode_r;
  mode_e      mode_nxt_s;
  logic       mode_prev_r;
  logic       press_s;
  logic       mode_evt_r;
  logic [3:0] led_mode_n_r;
  logic       led_out_n_r;

  assign raw_s = {bus.key_mode_n, bus.key_b_n, bus.key_a_n};

  // Two-flop synchroniser and per-key debounce counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r  <= 3'b111;
      sync2_r  <= 3'b111;
      stable_r <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_TERM) begin
          stable_r[i] <= sync2_r[i];
          cnt_r[i]    <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press is the 1 -> 0 transition of the debounced mode key.
  assign press_s = mode_prev_r & ~stable_r[2];

  // Next mode: one step per press, wrapping XNOR back to NAND.
  always_comb begin
    mode_nxt_s = mode_r;
    if (press_s) begin
      case (mode_r)
        MODE_NAND: mode_nxt_s = MODE_NOR;
        MODE_NOR:  mode_nxt_s = MODE_XOR;
        MODE_XOR:  mode_nxt_s = MODE_XNOR;
        MODE_XNOR: mode_nxt_s = MODE_NAND;
        default:   mode_nxt_s = MODE_NAND;
      endcase
    end else begin
      mode_nxt_s = mode_r;
    end
  end

  // Mode state register with event pulse and indicator decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r       <= MODE_NAND;
      mode_prev_r  <= 1'b1;
      mode_evt_r   <= 1'b0;
      led_mode_n_r <= 4'b1110;
    end else begin
      mode_r       <= mode_nxt_s;
      mode_prev_r  <= stable_r[2];
      mode_evt_r   <= press_s;
      led_mode_n_r <= mode_led_n(mode_nxt_s);
    end
  end

  // Gate result uses the current mode register, so a coincident mode step
  // shows up one cycle after a coincident operand change.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_out_n_r <= 1'b0;
    end else begin
      led_out_n_r <= gate_eval(mode_r, stable_r[0], stable_r[1]);
    end
  end

  assign bus.led_out_n  = led_out_n_r;
  assign bus.led_mode_n = led_mode_n_r;
  assign bus.mode       = mode_r;
  assign bus.mode_evt   = mode_evt_r;

endmodule

// File: tb/tb_logic_gate_ctrl.sv
// Scoreboard bench for logic_gate_ctrl with DEBOUNCE_CYCLES=4: stimulus pushes
// cycle-stamped expectations; negedge monitors pop and compare.
module tb_logic_gate_ctrl;

  localparam int K_LED  = 0;
  localparam int K_MODE = 1;
  localparam int K_LM   = 2;
  localparam int K_EVT  = 3;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  typedef struct {
    int mode;
    int lm;
  } evt_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   tb_mode = 0;
  exp_t sb[$];
  evt_t evq[$];

  logic_gate_ctrl_if bus();

  logic_gate_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input int kind);
    case (kind)
      K_LED:   return int'(bus.led_out_n);
      K_MODE:  return int'(bus.mode);
      K_LM:    return int'(bus.led_mode_n);
      default: return int'(bus.mode_evt);
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_LED:   return "led_out_n";
      K_MODE:  return "mode";
      K_LM:    return "led_mode_n";
      default: return "mode_evt";
    endcase
  endfunction

  // Cycle-stamped scoreboard: entries due now are compared; overdue ones count as misses.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_cmp++;
        if (sb[i].cyc < cyc || actual(sb[i].kind) != sb[i].val) begin
          n_err++;
          $display("FAIL %s @cyc %0d: got %0d, expected %0d (checked at %0d)",
                   kname(sb[i].kind), sb[i].cyc, actual(sb[i].kind), sb[i].val, cyc);
        end
        sb.delete(i);
      end
    end
  end

  // Every mode_evt pulse must match the next expected step, in order.
  always @(negedge clk) begin
    if (bus.mode_evt === 1'b1) begin
      n_cmp++;
      if (evq.size() == 0) begin
        n_err++;
        $display("FAIL mode_evt_unexpected @cyc %0d: got pulse, expected none (mode %0d)", cyc, bus.mode);
      end else begin
        evt_t e;
        e = evq.pop_front();
        if (int'(bus.mode) != e.mode || int'(bus.led_mode_n) != e.lm) begin
          n_err++;
          $display("FAIL mode_evt_step @cyc %0d: got mode %0d leds %b, expected mode %0d leds %b",
                   cyc, bus.mode, bus.led_mode_n, e.mode, e.lm[3:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input int kind, input int val);
    exp_t e;
    e.cyc = c;
    e.kind = kind;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_idle(input int c, input int led, input int m);
    expect_at(c, K_LED, led);
    expect_at(c, K_MODE, m);
    expect_at(c, K_LM, 15 & ~(1 << m));
    expect_at(c, K_EVT, 0);
  endtask

  task automatic push_evt(input int m);
    evt_t e;
    e.mode = m;
    e.lm = 15 & ~(1 << m);
    evq.push_back(e);
  endtask

  // Press at edge N: stable at N+6, mode step and pulse at N+7.
  task automatic mode_press();
    int n;
    n = cyc;
    bus.key_mode_n = 1'b0;
    expect_at(n + 6, K_MODE, tb_mode);
    tb_mode = (tb_mode + 1) % 4;
    push_evt(tb_mode);
    expect_at(n + 7, K_MODE, tb_mode);
    expect_at(n + 7, K_LM, 15 & ~(1 << tb_mode));
    expect_at(n + 7, K_EVT, 1);
    expect_at(n + 8, K_EVT, 0);
    tick(10);
    bus.key_mode_n = 1'b1;
    tick(10);
  endtask

  task automatic apply_ab(input logic a, input logic b, input int want);
    int n;
    n = cyc;
    bus.key_a_n = a;
    bus.key_b_n = b;
    expect_at(n + 7, K_LED, want);
    expect_at(n + 8, K_LED, want);
    tick(9);
  endtask

  // Truth table rows in mode order NAND, NOR, XOR, XNOR; columns (a,b) = 11,01,10,00.
  int tt [4][4] = '{'{0, 1, 1, 1}, '{0, 0, 0, 1}, '{0, 1, 1, 0}, '{1, 0, 0, 1}};
  logic pa [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic pb [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int n;
    rst = 1'b1;
    bus.key_a_n = 1'b1;
    bus.key_b_n = 1'b1;
    bus.key_mode_n = 1'b1;
    tick(3);
    rst = 1'b0;

    // Reset state, held while idle.
    n = cyc;
    expect_idle(n, 0, 0);
    expect_idle(n + 4, 0, 0);
    expect_idle(n + 8, 0, 0);
    tick(10);

    // Short glitch on A is rejected.
    n = cyc;
    bus.key_a_n = 1'b0;
    tick(3);
    bus.key_a_n = 1'b1;
    expect_idle(n + 7, 0, 0);
    expect_idle(n + 10, 0, 0);
    tick(12);

    // Held press on A: exact acceptance edge, then release.
    n = cyc;
    bus.key_a_n = 1'b0;
    expect_at(n + 6, K_LED, 0);
    expect_at(n + 7, K_LED, 1);
    tick(10);
    n = cyc;
    bus.key_a_n = 1'b1;
    expect_at(n + 6, K_LED, 1);
    expect_at(n + 7, K_LED, 0);
    tick(10);

    // Five presses: 1,2,3,0,1.
    for (int i = 0; i < 5; i++) mode_press();

    // Truth table in NOR, XOR, XNOR, NAND.
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < 4; p++) apply_ab(pa[p], pb[p], tt[tb_mode][p]);
      apply_ab(1'b1, 1'b1, tt[tb_mode][0]);
      mode_press();
    end

    // Reset while B's counter is at 2; B re-debounced from scratch.
    n = cyc;
    bus.key_b_n = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tb_mode = 0;
    expect_idle(n + 5, 0, 0);
    expect_at(n + 11, K_LED, 0);
    expect_at(n + 12, K_LED, 1);
    expect_at(n + 13, K_LED, 1);
    tick(12);
    bus.key_b_n = 1'b1;
    tick(12);

    // B press and mode press land on the same edge.
    n = cyc;
    bus.key_b_n = 1'b0;
    bus.key_mode_n = 1'b0;
    tb_mode = 1;
    push_evt(1);
    expect_at(n + 6, K_LED, 0);
    expect_at(n + 7, K_LED, 1);
    expect_at(n + 7, K_MODE, 1);
    expect_at(n + 8, K_LED, 0);
    expect_at(n + 10, K_LED, 0);
    tick(12);
    bus.key_b_n = 1'b1;
    bus.key_mode_n = 1'b1;
    tick(12);

    // Mode key held through reset counts as a fresh press afterwards.
    n = cyc;
    bus.key_mode_n = 1'b0;
    push_evt(2);
    expect_at(n + 7, K_MODE, 2);
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    push_evt(1);
    expect_at(n + 11, K_MODE, 0);
    expect_at(n + 11, K_LM, 14);
    expect_at(n + 17, K_MODE, 0);
    expect_at(n + 18, K_MODE, 1);
    expect_at(n + 18, K_EVT, 1);
    tick(10);
    bus.key_mode_n = 1'b1;
    tick(12);

    // Everything expected must have been consumed.
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    n_cmp++;
    if (evq.size() != 0) begin
      n_err++;
      $display("FAIL evt_drain: got %0d missing mode_evt pulses, expected 0", evq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
